// File: rtl/dsp_pkg.sv
// Shared helpers for the DSP datapath blocks: width arithmetic and default sizing.
package dsp_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_IW    = 16;
    localparam int DEF_LGMEM = 6;
    localparam int DEF_AW    = DEF_IW + DEF_LGMEM;
    localparam int DEF_LG    = clog2(DEF_LGMEM + 1);

endpackage

// File: rtl/boxcar_mem.sv
// Delay-line RAM for the boxcar: one write port, one read port with registered,
// read-first output so a same-address read returns the value being overwritten.
module boxcar_mem
    import dsp_pkg::*;
#(
    parameter int IW    = DEF_IW,
    parameter int LGMEM = DEF_LGMEM
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [LGMEM-1:0]     waddr_i,
    input  logic signed [IW-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [LGMEM-1:0]     raddr_i,
    output logic signed [IW-1:0] rdata_o
);

    logic signed [IW-1:0] mem [0:(1<<LGMEM)-1];
    logic signed [IW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem[raddr_i];
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/boxcar_avg.sv
// Running-average low-pass with run-time power-of-two length (1..2^LGMEM).
// Three-stage pipeline: delay-line access, accumulate, round/scale.
module boxcar_avg
    import dsp_pkg::*;
#(
    parameter int IW    = DEF_IW,
    parameter int LGMEM = DEF_LGMEM,
    localparam int LG   = clog2(LGMEM + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_areset_n,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_sample,
    input  logic [LG-1:0]        i_lgnavg,
    output logic                 o_ce,
    output logic signed [IW-1:0] o_sample
);

    localparam int AW = IW + LGMEM;

    logic [LG-1:0]        lg_sat, lgnavg_q, lgnavg_d;
    logic                 restart, accept, full;
    logic [LGMEM:0]       navg, fill_q, fill_d;
    logic [LGMEM-1:0]     wptr_q, wptr_d, raddr;
    logic signed [IW-1:0] old_rd, sample_p1_q;
    logic                 full_p1_q;
    logic                 vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic signed [AW-1:0] acc_q, acc_d, sample_ext, old_ext;
    logic                 o_ce_q, o_ce_d;
    logic signed [IW-1:0] o_sample_q, o_sample_d;

    // Round half up, scale by 2^lg, clamp to the output range.
    function automatic logic signed [IW-1:0] round_sat(input logic signed [AW-1:0] acc,
                                                       input logic [LG-1:0] lg);
        logic signed [AW:0]   half, sum, shifted;
        logic [AW-IW+1:0]     hi;
        half    = (lg != '0) ? ((AW+1)'(1) <<< (lg - LG'(1))) : '0;
        sum     = $signed({acc[AW-1], acc}) + half;
        shifted = sum >>> lg;
        hi      = shifted[AW:IW-1];
        if ((&hi) || !(|hi)) return shifted[IW-1:0];
        return shifted[AW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    endfunction

    assign lg_sat     = (i_lgnavg > LG'(LGMEM)) ? LG'(LGMEM) : i_lgnavg;
    assign restart    = (lg_sat != lgnavg_q);
    assign accept     = i_ce && !restart;
    assign navg       = {{LGMEM{1'b0}}, 1'b1} << lgnavg_q;
    assign raddr      = wptr_q - navg[LGMEM-1:0];
    assign full       = (fill_q >= navg);
    assign sample_ext = {{LGMEM{sample_p1_q[IW-1]}}, sample_p1_q};
    assign old_ext    = full_p1_q ? {{LGMEM{old_rd[IW-1]}}, old_rd} : '0;

    boxcar_mem #(
        .IW    (IW),
        .LGMEM (LGMEM)
    ) u_mem (
        .clk_i   (i_clk),
        .we_i    (accept),
        .waddr_i (wptr_q),
        .wdata_i (i_sample),
        .re_i    (accept),
        .raddr_i (raddr),
        .rdata_o (old_rd)
    );

    // A length change flushes history and everything still in flight.
    always_comb begin
        lgnavg_d   = lg_sat;
        wptr_d     = wptr_q;
        fill_d     = fill_q;
        vld_p1_d   = accept;
        vld_p2_d   = vld_p1_q && !restart;
        acc_d      = acc_q;
        o_ce_d     = vld_p2_q && !restart;
        o_sample_d = o_sample_q;
        if (restart) begin
            fill_d = '0;
            acc_d  = '0;
        end else begin
            if (accept) begin
                wptr_d = wptr_q + LGMEM'(1);
                if (!full) fill_d = fill_q + (LGMEM+1)'(1);
            end
            if (vld_p1_q) acc_d = acc_q + sample_ext - old_ext;
            if (vld_p2_q) o_sample_d = round_sat(acc_q, lgnavg_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            lgnavg_q   <= '0;
            wptr_q     <= '0;
            fill_q     <= '0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            acc_q      <= '0;
            o_ce_q     <= 1'b0;
            o_sample_q <= '0;
        end else begin
            lgnavg_q   <= lgnavg_d;
            wptr_q     <= wptr_d;
            fill_q     <= fill_d;
            vld_p1_q   <= vld_p1_d;
            vld_p2_q   <= vld_p2_d;
            acc_q      <= acc_d;
            o_ce_q     <= o_ce_d;
            o_sample_q <= o_sample_d;
        end
    end

    // Stage 0 -> 1 data: the sample and whether its oldest partner must be retired.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            sample_p1_q <= i_sample;
            full_p1_q   <= full;
        end
    end

    assign o_ce     = o_ce_q;
    assign o_sample = o_sample_q;

endmodule

// File: tb/tb_boxcar_avg.sv
// Bench for boxcar_avg: history-queue reference model compared every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
module tb_boxcar_avg;

    logic               clk;
    logic               rst_n;
    logic               ce;
    logic signed [15:0] sample;
    logic [2:0]         lgnavg;
    logic               o_ce;
    logic signed [15:0] o_sample;

    int errors;
    int checks;
    int cyc;

    int hist[$];
    int exp_due[$];
    int exp_val[$];
    int lg_m;
    bit exp_ce;
    int exp_sample;

    int got_v[$];
    int got_c[$];
    int first_in;

    boxcar_avg #(.IW(16), .LGMEM(6)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_ce       (ce),
        .i_sample   (sample),
        .i_lgnavg   (lgnavg),
        .o_ce       (o_ce),
        .o_sample   (o_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_due.delete();
        exp_val.delete();
        lg_m       = 0;
        exp_ce     = 1'b0;
        exp_sample = 0;
    endtask

    // Output n = round-half-up(sum of the last navg samples since restart / navg).
    task automatic model_step();
        int lgs, navg, sum, val, n;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lgs = (int'(lgnavg) > 6) ? 6 : int'(lgnavg);
        if (lgs != lg_m) begin
            lg_m = lgs;
            hist.delete();
            while (exp_due.size() > 0 && exp_due[$] >= cyc) begin
                void'(exp_due.pop_back());
                void'(exp_val.pop_back());
            end
        end else if (ce) begin
            hist.push_back(int'(sample));
            if (hist.size() > 64) void'(hist.pop_front());
            navg = 1 << lg_m;
            n    = (hist.size() < navg) ? hist.size() : navg;
            sum  = 0;
            for (int k = 0; k < n; k++) sum += hist[hist.size() - 1 - k];
            val = (sum + (navg >> 1)) >>> lg_m;
            if (val > 32767) val = 32767;
            if (val < -32768) val = -32768;
            exp_due.push_back(cyc + 2);
            exp_val.push_back(val);
        end
        if (exp_due.size() > 0 && exp_due[0] == cyc) begin
            exp_ce     = 1'b1;
            exp_sample = exp_val[0];
            void'(exp_due.pop_front());
            void'(exp_val.pop_front());
        end else begin
            exp_ce = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("o_ce", int'(o_ce), int'(exp_ce));
        chk("o_sample", int'(o_sample), exp_sample);
        if (o_ce) begin
            got_v.push_back(int'(o_sample));
            got_c.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        ce = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            ce     = 1'b1;
            sample = 16'(v);
            tick();
        end
        ce = 1'b0;
    endtask

    task automatic set_len(input int lg);
        lgnavg = 3'(lg);
        idle(2);
        got_v.delete();
        got_c.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        model_reset();
        rst_n  = 1'b1;
        ce     = 1'b0;
        sample = '0;
        lgnavg = 3'd0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_o_ce", int'(o_ce), 0);
        chk("reset_o_sample", int'(o_sample), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Constant input, length 4.
        set_len(2);
        first_in = cyc + 1;
        send(100, 8);
        idle(4);
        chk("const_count", got_v.size(), 8);
        if (got_v.size() >= 5) begin
            chk("const_0", got_v[0], 25);
            chk("const_1", got_v[1], 50);
            chk("const_2", got_v[2], 75);
            chk("const_3", got_v[3], 100);
            chk("const_4", got_v[4], 100);
            chk("const_latency", got_c[0] - first_in, 3);
        end

        // Impulse, length 8, one input every 4th clock.
        set_len(3);
        for (int i = 0; i < 12; i++) begin
            send((i == 0) ? 1000 : 0, 1);
            idle(3);
        end
        idle(3);
        chk("imp_count", got_v.size(), 12);
        if (got_v.size() == 12) begin
            chk("imp_first", got_v[0], 125);
            chk("imp_eighth", got_v[7], 125);
            chk("imp_ninth", got_v[8], 0);
            chk("imp_last", got_v[11], 0);
            chk("imp_spacing", got_c[1] - got_c[0], 4);
        end

        // Negative rounding, length 2.
        set_len(1);
        send(-3, 6);
        idle(4);
        chk("neg_count", got_v.size(), 6);
        if (got_v.size() == 6) begin
            chk("neg_0", got_v[0], -1);
            chk("neg_1", got_v[1], -3);
            chk("neg_5", got_v[5], -3);
        end

        // Pass-through, length 1.
        set_len(0);
        send(1234, 1);
        send(-777, 1);
        idle(4);
        chk("pass_count", got_v.size(), 2);
        if (got_v.size() == 2) begin
            chk("pass_0", got_v[0], 1234);
            chk("pass_1", got_v[1], -777);
        end

        // Full depth ramp; out-of-range length saturates, re-selecting 6 is not a change.
        set_len(7);
        for (int n = 0; n < 200; n++) begin
            if (n == 100) lgnavg = 3'd6;
            send(n, 1);
        end
        idle(4);
        chk("ramp_count", got_v.size(), 200);
        if (got_v.size() == 200) begin
            chk("ramp_10", got_v[10], 1);
            chk("ramp_63", got_v[63], 32);
            chk("ramp_199", got_v[199], 168);
        end

        // Full-scale extremes at full depth.
        got_v.delete();
        send(-32768, 70);
        idle(4);
        if (got_v.size() > 0) chk("min_steady", got_v[$], -32768);
        got_v.delete();
        send(32767, 70);
        idle(4);
        if (got_v.size() > 0) chk("max_steady", got_v[$], 32767);

        // Length change mid-stream drops in-flight results and restarts the fill.
        set_len(2);
        send(64, 8);
        lgnavg = 3'd4;
        send(64, 20);
        idle(4);
        chk("chg_count", got_v.size(), 25);
        if (got_v.size() == 25) begin
            chk("chg_old_last", got_v[5], 64);
            chk("chg_new_0", got_v[6], 4);
            chk("chg_new_1", got_v[7], 8);
            chk("chg_new_15", got_v[21], 64);
        end

        // Asynchronous reset with samples in flight.
        set_len(2);
        send(40, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_o_ce", int'(o_ce), 0);
        chk("rst_async_o_sample", int'(o_sample), 0);
        tick();
        rst_n = 1'b1;
        got_v.delete();
        got_c.delete();
        idle(4);
        chk("rst_no_stale", got_v.size(), 0);
        send(40, 4);
        idle(4);
        chk("rst_count", got_v.size(), 4);
        if (got_v.size() == 4) begin
            chk("rst_first", got_v[0], 10);
            chk("rst_last", got_v[3], 40);
        end

        // Randomized traffic and length changes.
        for (int i = 0; i < 1500; i++) begin
            int r;
            if ($urandom_range(0, 199) == 0) lgnavg = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            ce     = ($urandom_range(0, 3) != 0);
            sample = (r == 0) ? 16'sh8000 : (r == 1) ? 16'sh7fff : 16'($urandom);
            tick();
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
